// File: rtl/pinball_screen_pkg.sv
// Shared types and constants for the main-screen post-processing effects.
package pinball_screen_pkg;

    // Effect sequencer states.
    typedef enum logic [2:0] {
        IDLE,
        FLASH,
        FADE_OUT,
        BLACK,
        FADE_IN
    } effect_state_t;

    // RGB332 field positions: R[7:5], G[4:2], B[1:0].
    localparam int R_MSB = 7;
    localparam int R_LSB = 5;
    localparam int G_MSB = 4;
    localparam int G_LSB = 2;
    localparam int B_MSB = 1;
    localparam int B_LSB = 0;

    // Channel tables indexed 0=R, 1=G, 2=B so the scaler can loop over fields.
    localparam int CH_COUNT = 3;
    localparam int CH_MSB [CH_COUNT] = '{R_MSB, G_MSB, B_MSB};
    localparam int CH_LSB [CH_COUNT] = '{R_LSB, G_LSB, B_LSB};

    // Brightness level: 0 is black, LEVEL_MAX is full brightness.
    localparam int LEVEL_W = 4;
    localparam logic [LEVEL_W-1:0] LEVEL_MAX = 4'd8;

endpackage

// File: rtl/rgb332_scaler.sv
// Combinational brightness scaler for an RGB332 pixel.
// Each channel becomes (channel * level) >> 3, so level 8 passes the pixel
// through unchanged and level 0 gives black. The fractional bits are dropped
// (floor), never rounded.
module rgb332_scaler
    import pinball_screen_pkg::*;
(
    input  logic [7:0]         pixel,
    input  logic [LEVEL_W-1:0] level,
    output logic [7:0]         scaled
);

    genvar gi;
    generate
        for (gi = 0; gi < CH_COUNT; gi++) begin : g_chan
            localparam int W = CH_MSB[gi] - CH_LSB[gi] + 1;

            logic [W-1:0] chan;

            assign chan = pixel[CH_MSB[gi]:CH_LSB[gi]];

            // Both operands are widened so the full product (up to 7*8=56)
            // is kept before the divide-by-8 shift.
            assign scaled[CH_MSB[gi]:CH_LSB[gi]] =
                W'(({{LEVEL_W{1'b0}}, chan} * {{W{1'b0}}, level}) >> 3);
        end
    endgenerate

endmodule

// File: rtl/screen_effects_fader.sv
// Game-event effects on the main-screen pixel: colour-invert flash and
// frame-timed fade to black / fade back in. All timing is in frames,
// counted on the start-of-frame pulse.
module screen_effects_fader
    import pinball_screen_pkg::*;
#(
    parameter int FLASH_FRAMES     = 4,
    parameter int FADE_STEP_FRAMES = 2
)(
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         RGB_screen_main,
    input  logic               startOfFrame,
    input  logic               flash_trigger,
    input  logic               fade_out_req,
    input  logic               fade_in_req,
    output logic [7:0]         RGB_out,
    output logic [LEVEL_W-1:0] fade_level,
    output logic               effect_busy
);

    localparam logic [3:0] FLASH_LOAD = 4'(FLASH_FRAMES);
    localparam logic [3:0] STEP_LAST  = 4'(FADE_STEP_FRAMES - 1);

    effect_state_t        state_reg;
    logic [LEVEL_W-1:0]   level_reg;
    logic [3:0]           flash_cnt_reg;
    logic [3:0]           step_cnt_reg;
    logic                 busy_reg;
    logic [7:0]           rgb_reg;
    logic [7:0]           scaled_pixel;

    rgb332_scaler u_scaler (
        .pixel  (RGB_screen_main),
        .level  (level_reg),
        .scaled (scaled_pixel)
    );

    // Sequencer, frame counters and registered pixel output. The output for
    // the next cycle is chosen from the current state, so a request accepted
    // this cycle first shows on RGB_out two cycles later. effect_busy is
    // written alongside every state change so it tracks state exactly.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            level_reg     <= LEVEL_MAX;
            flash_cnt_reg <= 4'd0;
            step_cnt_reg  <= 4'd0;
            busy_reg      <= 1'b0;
            rgb_reg       <= 8'h00;
        end else begin
            case (state_reg)
                IDLE:     rgb_reg <= RGB_screen_main;
                FLASH:    rgb_reg <= ~RGB_screen_main;
                FADE_OUT: rgb_reg <= scaled_pixel;
                FADE_IN:  rgb_reg <= scaled_pixel;
                default:  rgb_reg <= 8'h00;
            endcase

            case (state_reg)
                IDLE: begin
                    // Fade-out beats a simultaneous flash; fade-in means
                    // nothing when already at full brightness.
                    if (fade_out_req) begin
                        state_reg    <= FADE_OUT;
                        step_cnt_reg <= 4'd0;
                        busy_reg     <= 1'b1;
                    end else if (flash_trigger) begin
                        state_reg     <= FLASH;
                        flash_cnt_reg <= FLASH_LOAD;
                        busy_reg      <= 1'b1;
                    end
                end

                FLASH: begin
                    if (fade_out_req) begin
                        state_reg     <= FADE_OUT;
                        step_cnt_reg  <= 4'd0;
                        flash_cnt_reg <= 4'd0;
                    end else if (flash_trigger) begin
                        // Retrigger restarts the full flash, even on a frame pulse.
                        flash_cnt_reg <= FLASH_LOAD;
                    end else if (startOfFrame) begin
                        if (flash_cnt_reg <= 4'd1) begin
                            state_reg     <= IDLE;
                            flash_cnt_reg <= 4'd0;
                            busy_reg      <= 1'b0;
                        end else begin
                            flash_cnt_reg <= flash_cnt_reg - 4'd1;
                        end
                    end
                end

                FADE_OUT: begin
                    if (fade_in_req && !fade_out_req) begin
                        state_reg    <= FADE_IN;
                        step_cnt_reg <= 4'd0;
                    end else if (startOfFrame) begin
                        if (step_cnt_reg >= STEP_LAST) begin
                            step_cnt_reg <= 4'd0;
                            // Saturate at 0; reaching 0 parks the screen black.
                            if (level_reg <= 4'd1) begin
                                level_reg <= 4'd0;
                                state_reg <= BLACK;
                            end else begin
                                level_reg <= level_reg - 4'd1;
                            end
                        end else begin
                            step_cnt_reg <= step_cnt_reg + 4'd1;
                        end
                    end
                end

                BLACK: begin
                    if (fade_in_req) begin
                        state_reg    <= FADE_IN;
                        step_cnt_reg <= 4'd0;
                    end
                end

                FADE_IN: begin
                    if (fade_out_req) begin
                        state_reg    <= FADE_OUT;
                        step_cnt_reg <= 4'd0;
                    end else if (startOfFrame) begin
                        if (step_cnt_reg >= STEP_LAST) begin
                            step_cnt_reg <= 4'd0;
                            // Saturate at full brightness and hand back to pass-through.
                            if (level_reg >= LEVEL_MAX - 4'd1) begin
                                level_reg <= LEVEL_MAX;
                                state_reg <= IDLE;
                                busy_reg  <= 1'b0;
                            end else begin
                                level_reg <= level_reg + 4'd1;
                            end
                        end else begin
                            step_cnt_reg <= step_cnt_reg + 4'd1;
                        end
                    end
                end

                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign RGB_out     = rgb_reg;
    assign fade_level  = level_reg;
    assign effect_busy = busy_reg;

endmodule
